// File: rtl/alu_pkg.sv
// Shared ALU-control constants, funct codes, FSM state enum and decode record.
package alu_pkg;

  localparam logic [1:0] OP_MEM   = 2'b00;
  localparam logic [1:0] OP_BR    = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_IMM   = 2'b11;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLL  = 4'b1000;
  localparam logic [3:0] CTRL_SRL  = 4'b1001;
  localparam logic [3:0] CTRL_SRA  = 4'b1010;
  localparam logic [3:0] CTRL_XOR  = 4'b0100;
  localparam logic [3:0] CTRL_MULT = 4'b0101;
  localparam logic [3:0] CTRL_DIV  = 4'b1011;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       is_mul;
    logic       is_div;
  } dec_t;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// Divider datapath exists only when ALU_CTRL_DIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
`ifdef ALU_CTRL_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] nxt_hi_o,
  output logic [WIDTH-1:0] nxt_lo_o
);

  // hi_q: partial product high half / running remainder
  // lo_q: multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   sum, addend;

`ifdef ALU_CTRL_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   r_sh, diff;
  logic             take;
`endif

  always_comb begin
    sum    = {1'b0, hi_q} + {1'b0, opb_q};
    addend = lo_q[0] ? sum : {1'b0, hi_q};
    hi_d   = addend[WIDTH:1];
    lo_d   = {addend[0], lo_q[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
    r_sh = {hi_q, lo_q[WIDTH-1]};
    diff = r_sh - {1'b0, opb_q};
    // zero divisor always "subtracts": quotient all ones, remainder = dividend
    take = ~diff[WIDTH] | (opb_q == '0);
    if (div_q) begin
      hi_d = take ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], take};
    end
`endif
  end

  assign nxt_hi_o = hi_d;
  assign nxt_lo_o = lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
`ifdef ALU_CTRL_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      opb_q <= b_i;
`ifdef ALU_CTRL_DIV_EN
      div_q <= is_div_i;
`endif
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder plus sequencer for iterative mult/div.
// Divide support compiled in only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  dec_t             dec;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, lo_q, nxt_hi, nxt_lo;
  logic             accept, start, last_step;

  always_comb begin
    dec = '{ctrl: CTRL_AND, illegal: 1'b1, is_mul: 1'b0, is_div: 1'b0};
    unique case (alu_op)
      OP_MEM: begin dec.ctrl = CTRL_ADD; dec.illegal = 1'b0; end
      OP_BR:  begin dec.ctrl = CTRL_SUB; dec.illegal = 1'b0; end
      OP_IMM: if (funct == F_AND) dec.illegal = 1'b0;
      OP_RTYPE: begin
        dec.illegal = 1'b0;
        case (funct)
          F_AND:  dec.ctrl = CTRL_AND;
          F_OR:   dec.ctrl = CTRL_OR;
          F_ADD:  dec.ctrl = CTRL_ADD;
          F_SUB:  dec.ctrl = CTRL_SUB;
          F_NOR:  dec.ctrl = CTRL_NOR;
          F_SLT:  dec.ctrl = CTRL_SLT;
          F_SLL:  dec.ctrl = CTRL_SLL;
          F_SRL:  dec.ctrl = CTRL_SRL;
          F_SRA:  dec.ctrl = CTRL_SRA;
          F_XOR:  dec.ctrl = CTRL_XOR;
          F_MULT: begin dec.ctrl = CTRL_MULT; dec.is_mul = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
          F_DIV:  begin dec.ctrl = CTRL_DIV; dec.is_div = 1'b1; end
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign alu_ctrl  = dec.ctrl;
  assign illegal   = dec.illegal;
  assign accept    = in_valid && in_ready;
  assign start     = accept && (dec.is_mul || dec.is_div);
  assign last_step = stall && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) cnt_d = '0;
        if (accept && dec.is_mul) state_d = S_MUL;
`ifdef ALU_CTRL_DIV_EN
        else if (accept && dec.is_div) state_d = S_DIV;
`endif
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    stall     = (state_q == S_MUL) || (state_q == S_DIV);
    out_valid = (state_q == S_DONE);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
`ifdef ALU_CTRL_DIV_EN
    .is_div_i (dec.is_div),
`endif
    .step_i   (stall),
    .a_i      (op_a),
    .b_i      (op_b),
    .nxt_hi_o (nxt_hi),
    .nxt_lo_o (nxt_lo)
  );

  // Results are captured from the final step so hi/lo never show partial work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last_step) begin
      hi_q <= nxt_hi;
      lo_q <= nxt_lo;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

`ifdef ALU_CTRL_DIV_EN
  logic div0_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     div0_q <= 1'b0;
    else if (start) div0_q <= dec.is_div && (op_b == '0);
  end
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

endmodule
